// File: rtl/pipe_stage_regs.sv
// Fetch PC, F/D and D/E pipeline registers for the 5-stage RV32I core.
// Valid bits mark bubbles; saturating counters record stall and flush events.
module pipe_stage_regs #(
    parameter int unsigned           word_width = 32,
    parameter logic [word_width-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [word_width-1:0] NOP_INSTR  = 32'h0000_0013,
    parameter int unsigned           CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  FlushE,
    input  logic [word_width-1:0] PCNextF,
    input  logic [word_width-1:0] InstrF,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  cnt_clr,
    output logic [word_width-1:0] PCF,
    output logic [word_width-1:0] InstrD,
    output logic [word_width-1:0] PCD,
    output logic                  ValidD,
    output logic [4:0]            Rs1D,
    output logic [4:0]            Rs2D,
    output logic [4:0]            RdD,
    output logic [4:0]            Rs1E,
    output logic [4:0]            Rs2E,
    output logic [4:0]            RdE,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic [word_width-1:0] PCE,
    output logic                  ValidE,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic stall_event;
    logic flush_event;

    // Fetch PC: a stall holds even a redirect target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            PCF <= PCNextF;
        end
    end

    // F/D register: flush beats stall, and a flush inserts a NOP bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            InstrD <= NOP_INSTR;
            PCD    <= '0;
            ValidD <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            PCD    <= '0;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            InstrD <= InstrF;
            PCD    <= PCF;
            ValidD <= 1'b1;
        end
    end

    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];
    assign RdD  = InstrD[11:7];

    // D/E register: controls are masked by ValidD so a bubble can never
    // trigger forwarding or a load-use stall in the hazard unit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Rs1E       <= '0;
            Rs2E       <= '0;
            RdE        <= '0;
            RegWriteE  <= 1'b0;
            ResultSrcE <= '0;
            PCE        <= '0;
            ValidE     <= 1'b0;
        end else if (FlushE) begin
            Rs1E       <= '0;
            Rs2E       <= '0;
            RdE        <= '0;
            RegWriteE  <= 1'b0;
            ResultSrcE <= '0;
            PCE        <= '0;
            ValidE     <= 1'b0;
        end else begin
            Rs1E       <= Rs1D;
            Rs2E       <= Rs2D;
            RdE        <= RdD;
            RegWriteE  <= RegWriteD & ValidD;
            ResultSrcE <= ValidD ? ResultSrcD : 2'b00;
            PCE        <= PCD;
            ValidE     <= ValidD;
        end
    end

    // A cycle with both stall and flush counts only as a flush.
    assign stall_event = StallD & ~FlushD;
    assign flush_event = FlushD;

    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cur,
        input logic             ev,
        input logic             clr
    );
        logic [CNT_W-1:0] res;
        res = cur;
        if (clr) begin
            res = '0;
        end else if (ev && (cur != CNT_MAX)) begin
            res = cur + CNT_W'(1);
        end
        return res;
    endfunction

    // Saturating performance counters with synchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= cnt_next(stall_cnt, stall_event, cnt_clr);
            flush_cnt <= cnt_next(flush_cnt, flush_event, cnt_clr);
        end
    end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed table-driven bench for pipe_stage_regs (4-bit counters so saturation is reachable).
module tb_pipe_stage_regs;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] IA   = 32'h0000_A283; // lw   x5, 0(x1)
    localparam logic [31:0] IB   = 32'h0022_8333; // add  x6, x5, x2
    localparam logic [31:0] IC   = 32'h0011_8393; // addi x7, x3, 1
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset_n;
    logic        StallF, StallD, FlushD, FlushE;
    logic [31:0] PCNextF, InstrF;
    logic        RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        cnt_clr;
    logic [31:0] PCF, InstrD, PCD, PCE;
    logic        ValidD, ValidE, RegWriteE;
    logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  stall_cnt, flush_cnt;

    int pass_cnt = 0;
    int total    = 0;

    pipe_stage_regs #(
        .word_width(32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .PCNextF   (PCNextF),
        .InstrF    (InstrF),
        .RegWriteD (RegWriteD),
        .ResultSrcD(ResultSrcD),
        .cnt_clr   (cnt_clr),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .ValidD    (ValidD),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdD       (RdD),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RegWriteE (RegWriteE),
        .ResultSrcE(ResultSrcE),
        .PCE       (PCE),
        .ValidE    (ValidE),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall_f;
        logic        stall_d;
        logic        flush_d;
        logic        flush_e;
        logic        clr;
        logic        rw_d;
        logic [1:0]  rs_d;
        logic [31:0] pc_next;
        logic [31:0] instr_f;
        logic [31:0] e_pcf;
        logic [31:0] e_instr_d;
        logic [31:0] e_pcd;
        logic        e_vd;
        logic [4:0]  e_rs1e;
        logic [4:0]  e_rs2e;
        logic [4:0]  e_rde;
        logic        e_rwe;
        logic [1:0]  e_rse;
        logic [31:0] e_pce;
        logic        e_ve;
        logic [3:0]  e_stall;
        logic [3:0]  e_flush;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic fe,
                         input logic clr, input logic [31:0] pcn, input logic [31:0] ins);
        StallF  = sf;
        StallD  = sd;
        FlushD  = fd;
        FlushE  = fe;
        cnt_clr = clr;
        PCNextF = pcn;
        InstrF  = ins;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".PCF"},        PCF, 32'h0);
        chk({tag, ".InstrD"},     InstrD, NOP);
        chk({tag, ".PCD"},        PCD, 32'h0);
        chk({tag, ".ValidD"},     32'(ValidD), 32'h0);
        chk({tag, ".Rs1E"},       32'(Rs1E), 32'h0);
        chk({tag, ".Rs2E"},       32'(Rs2E), 32'h0);
        chk({tag, ".RdE"},        32'(RdE), 32'h0);
        chk({tag, ".RegWriteE"},  32'(RegWriteE), 32'h0);
        chk({tag, ".ResultSrcE"}, 32'(ResultSrcE), 32'h0);
        chk({tag, ".PCE"},        PCE, 32'h0);
        chk({tag, ".ValidE"},     32'(ValidE), 32'h0);
        chk({tag, ".stall_cnt"},  32'(stall_cnt), 32'h0);
        chk({tag, ".flush_cnt"},  32'(flush_cnt), 32'h0);
    endtask

    initial begin
        // stall_f stall_d flush_d flush_e clr rw_d rs_d pc_next instr_f |
        // pcf instr_d pcd vd rs1e rs2e rde rwe rse pce ve stall flush
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h4, IA,
                    32'h4, IA, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 4'd0, 4'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h8, IB,
                    32'h8, IB, 32'h4, 1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 2'd1, 32'h0, 1'b1, 4'd0, 4'd0};
        // load-use: hold F and D, bubble into E
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'hC, IC,
                    32'h8, IB, 32'h4, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 4'd1, 4'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'hC, IC,
                    32'hC, IC, 32'h8, 1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 2'd0, 32'h4, 1'b1, 4'd1, 4'd0};
        // taken branch
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h100, JUNK,
                    32'h100, NOP, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 4'd1, 4'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h104, IA,
                    32'h104, IA, 32'h100, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 4'd1, 4'd1};
        // stall and flush together: flush wins, counted as flush only
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h108, IB,
                    32'h104, NOP, 32'h0, 1'b0, 5'd1, 5'd0, 5'd5, 1'b1, 2'd1, 32'h100, 1'b1, 4'd1, 4'd2};
        // invalid D stage: RegWrite and ResultSrc masked
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h108, IB,
                    32'h108, IB, 32'h104, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 4'd1, 4'd2};
        // clear coincident with a stall event
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'h10C, IC,
                    32'h108, IB, 32'h104, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 4'd0, 4'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h10C, IC,
                    32'h10C, IC, 32'h108, 1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 2'd0, 32'h104, 1'b1, 4'd0, 4'd0};

        reset_n    = 1'b0;
        RegWriteD  = 1'b0;
        ResultSrcD = 2'd0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        chk_reset_values("reset");
        chk("reset.Rs1D", 32'(Rs1D), 32'h0);
        chk("reset.RdD",  32'(RdD),  32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].stall_f, vecs[i].stall_d, vecs[i].flush_d, vecs[i].flush_e,
                  vecs[i].clr, vecs[i].pc_next, vecs[i].instr_f);
            RegWriteD  = vecs[i].rw_d;
            ResultSrcD = vecs[i].rs_d;
            step();
            chk($sformatf("v%0d.PCF", i),        PCF, vecs[i].e_pcf);
            chk($sformatf("v%0d.InstrD", i),     InstrD, vecs[i].e_instr_d);
            chk($sformatf("v%0d.PCD", i),        PCD, vecs[i].e_pcd);
            chk($sformatf("v%0d.ValidD", i),     32'(ValidD), 32'(vecs[i].e_vd));
            chk($sformatf("v%0d.Rs1D", i),       32'(Rs1D), 32'(vecs[i].e_instr_d[19:15]));
            chk($sformatf("v%0d.Rs2D", i),       32'(Rs2D), 32'(vecs[i].e_instr_d[24:20]));
            chk($sformatf("v%0d.RdD", i),        32'(RdD), 32'(vecs[i].e_instr_d[11:7]));
            chk($sformatf("v%0d.Rs1E", i),       32'(Rs1E), 32'(vecs[i].e_rs1e));
            chk($sformatf("v%0d.Rs2E", i),       32'(Rs2E), 32'(vecs[i].e_rs2e));
            chk($sformatf("v%0d.RdE", i),        32'(RdE), 32'(vecs[i].e_rde));
            chk($sformatf("v%0d.RegWriteE", i),  32'(RegWriteE), 32'(vecs[i].e_rwe));
            chk($sformatf("v%0d.ResultSrcE", i), 32'(ResultSrcE), 32'(vecs[i].e_rse));
            chk($sformatf("v%0d.PCE", i),        PCE, vecs[i].e_pce);
            chk($sformatf("v%0d.ValidE", i),     32'(ValidE), 32'(vecs[i].e_ve));
            chk($sformatf("v%0d.stall_cnt", i),  32'(stall_cnt), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d.flush_cnt", i),  32'(flush_cnt), 32'(vecs[i].e_flush));
        end

        // stall counter saturation, then clear while still stalling
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, JUNK);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14) chk("sat.stall14", 32'(stall_cnt), 32'd14);
            if (k == 15) chk("sat.stall15", 32'(stall_cnt), 32'd15);
        end
        chk("sat.stall20", 32'(stall_cnt), 32'd15);
        chk("sat.PCF_held", PCF, 32'h10C);
        chk("sat.InstrD_held", InstrD, IC);
        cnt_clr = 1'b1;
        step();
        chk("sat.clr", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b0;
        step();
        chk("sat.after_clr", 32'(stall_cnt), 32'd1);

        // flush counter saturation
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, JUNK);
        for (int k = 1; k <= 17; k++) step();
        chk("satf.flush", 32'(flush_cnt), 32'd15);
        chk("satf.stall", 32'(stall_cnt), 32'd1);
        chk("satf.ValidD", 32'(ValidD), 32'h0);

        // fill the pipe, then pulse reset between edges
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, IB);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h208, IC);
        step();
        chk("pre_rst.ValidE", 32'(ValidE), 32'h1);
        chk("pre_rst.PCF", PCF, 32'h208);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        step();
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, IA);
        step();
        chk("post_rst.PCF", PCF, 32'h40);
        chk("post_rst.InstrD", InstrD, IA);
        chk("post_rst.PCD", PCD, 32'h0);
        chk("post_rst.ValidD", 32'(ValidD), 32'h1);
        chk("post_rst.ValidE", 32'(ValidE), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
